// File: rtl/rmw_pixel_engine.sv
// Read-modify-write pixel engine for a planar frame buffer.
//
// A request names a base word address (plane 0), a pixel slot within each word, a colour
// (one PIX_W slice per plane) and a raster op. The engine reads one word per plane through
// the shared arbiter, then for each plane rewrites the selected slot with
// f(old slot, colour slice) and writes the word back.
//
// Ports:
//   clk, rst_     clock (rising edge) and synchronous active-low reset
//   addr_base     word address of plane 0
//   addr_offset   pixel slot within each word
//   color         pixel colour; plane 0 occupies the most significant slice
//   mode          raster op: 0 replace, 1 XOR, 2 OR, 3 AND
//   addr_rts/rtr  request handshake (ready only when idle)
//   in_data       read return data, qualified by bcast_xfc
//   out_addr      memory address, out_data write data
//   arb_rts/rtr   arbiter handshake
//   wr_op         byte enables: all ones for a write, all zeros for a read
//   busy          high whenever not idle
//   done          one-cycle completion pulse
module rmw_pixel_engine #(
  parameter int unsigned ADDR_W         = 17,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned PIX_W          = 4,
  parameter int unsigned PLANES         = 3,
  parameter bit          SKIP_UNCHANGED = 1'b0,
  localparam int unsigned OFFS_W        = $clog2(DATA_W / PIX_W)
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic [ADDR_W-1:0]       addr_base,
  input  logic [OFFS_W-1:0]       addr_offset,
  input  logic [PLANES*PIX_W-1:0] color,
  input  logic [1:0]              mode,
  input  logic                    addr_rts,
  output logic                    addr_rtr,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    bcast_xfc,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [DATA_W-1:0]       out_data,
  output logic                    arb_rts,
  input  logic                    arb_rtr,
  output logic [DATA_W/8-1:0]     wr_op,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned PL_W = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam logic [PL_W-1:0] LastPl = PL_W'(PLANES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StModify,
    StWrReq,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [PL_W-1:0]         pl_q, pl_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [OFFS_W-1:0]       offs_q, offs_d;
  logic [PLANES*PIX_W-1:0] color_q, color_d;
  logic [1:0]              mode_q, mode_d;
  logic [ADDR_W-1:0]       out_addr_q, out_addr_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic [DATA_W-1:0]       rbuf_q [PLANES];
  logic                    rbuf_we;

  logic              addr_xfc, arb_xfc, pl_last;
  logic [31:0]       sh_off, sh_col;
  logic [PIX_W-1:0]  old_slot, col_slice, new_slot;
  logic [DATA_W-1:0] cur_word, slot_mask, mod_word;

  assign addr_rtr = (state_q == StIdle);
  assign arb_rts  = (state_q == StRdReq) || (state_q == StWrReq);
  assign wr_op    = (state_q == StWrReq) ? '1 : '0;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;

  assign addr_xfc = addr_rts & addr_rtr;
  assign arb_xfc  = arb_rts & arb_rtr;
  assign pl_last  = (pl_q == LastPl);

  // Slot merge for the current plane. Plane 0 takes the most significant colour slice.
  always_comb begin
    cur_word  = rbuf_q[pl_q];
    sh_off    = 32'(offs_q) * PIX_W;
    sh_col    = (PLANES - 1 - 32'(pl_q)) * PIX_W;
    old_slot  = PIX_W'(cur_word >> sh_off);
    col_slice = PIX_W'(color_q >> sh_col);
    unique case (mode_q)
      2'd0: new_slot = col_slice;
      2'd1: new_slot = old_slot ^ col_slice;
      2'd2: new_slot = old_slot | col_slice;
      2'd3: new_slot = old_slot & col_slice;
    endcase
    slot_mask = DATA_W'({PIX_W{1'b1}}) << sh_off;
    mod_word  = (cur_word & ~slot_mask) | (DATA_W'(new_slot) << sh_off);
  end

  always_comb begin
    state_d    = state_q;
    pl_d       = pl_q;
    base_d     = base_q;
    offs_d     = offs_q;
    color_d    = color_q;
    mode_d     = mode_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    rbuf_we    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (addr_xfc) begin
          base_d     = addr_base;
          offs_d     = addr_offset;
          color_d    = color;
          mode_d     = mode;
          pl_d       = '0;
          out_addr_d = addr_base;
          state_d    = StRdReq;
        end
      end
      StRdReq: begin
        if (arb_xfc) state_d = StRdWait;
      end
      StRdWait: begin
        // Returns are only meaningful here; strobes in any other state are dropped.
        if (bcast_xfc) begin
          rbuf_we = 1'b1;
          if (pl_last) begin
            pl_d    = '0;
            state_d = StModify;
          end else begin
            pl_d       = pl_q + 1'b1;
            out_addr_d = base_q + ADDR_W'(pl_d);
            state_d    = StRdReq;
          end
        end
      end
      StModify: begin
        out_addr_d = base_q + ADDR_W'(pl_q);
        out_data_d = mod_word;
        if (SKIP_UNCHANGED && (mod_word == cur_word)) begin
          if (pl_last) begin
            state_d = StDone;
          end else begin
            pl_d = pl_q + 1'b1;
          end
        end else begin
          state_d = StWrReq;
        end
      end
      StWrReq: begin
        if (arb_xfc) begin
          if (pl_last) begin
            state_d = StDone;
          end else begin
            pl_d    = pl_q + 1'b1;
            state_d = StModify;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q    <= StIdle;
      pl_q       <= '0;
      base_q     <= '0;
      offs_q     <= '0;
      color_q    <= '0;
      mode_q     <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      for (int unsigned i = 0; i < PLANES; i++) begin
        rbuf_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pl_q       <= pl_d;
      base_q     <= base_d;
      offs_q     <= offs_d;
      color_q    <= color_d;
      mode_q     <= mode_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      if (rbuf_we) rbuf_q[pl_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_rmw_pixel_engine.sv
// Bench for rmw_pixel_engine: two instances (plain and SKIP_UNCHANGED) share request
// stimulus; each has its own memory/arbiter responder. Results are compared with a
// per-plane arithmetic model of the pixel update.
module tb_rmw_pixel_engine;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PIX_W  = 4;
  localparam int unsigned PLANES = 3;
  localparam int unsigned OFFS_W = 3;
  localparam int unsigned BE_W   = DATA_W / 8;

  logic clk, rst_;
  logic [ADDR_W-1:0]       addr_base;
  logic [OFFS_W-1:0]       addr_offset;
  logic [PLANES*PIX_W-1:0] color;
  logic [1:0]              mode;

  logic              addr_rts  [2];
  logic              addr_rtr  [2];
  logic [DATA_W-1:0] in_data   [2];
  logic              bcast_xfc [2];
  logic [ADDR_W-1:0] out_addr  [2];
  logic [DATA_W-1:0] out_data  [2];
  logic              arb_rts   [2];
  logic              arb_rtr   [2];
  logic [BE_W-1:0]   wr_op     [2];
  logic              busy      [2];
  logic              done      [2];

  rmw_pixel_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIX_W(PIX_W), .PLANES(PLANES), .SKIP_UNCHANGED(1'b0)
  ) u_dut (
    .clk(clk), .rst_(rst_), .addr_base(addr_base), .addr_offset(addr_offset), .color(color),
    .mode(mode), .addr_rts(addr_rts[0]), .addr_rtr(addr_rtr[0]), .in_data(in_data[0]),
    .bcast_xfc(bcast_xfc[0]), .out_addr(out_addr[0]), .out_data(out_data[0]),
    .arb_rts(arb_rts[0]), .arb_rtr(arb_rtr[0]), .wr_op(wr_op[0]), .busy(busy[0]),
    .done(done[0])
  );

  rmw_pixel_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIX_W(PIX_W), .PLANES(PLANES), .SKIP_UNCHANGED(1'b1)
  ) u_dut_skip (
    .clk(clk), .rst_(rst_), .addr_base(addr_base), .addr_offset(addr_offset), .color(color),
    .mode(mode), .addr_rts(addr_rts[1]), .addr_rtr(addr_rtr[1]), .in_data(in_data[1]),
    .bcast_xfc(bcast_xfc[1]), .out_addr(out_addr[1]), .out_data(out_data[1]),
    .arb_rts(arb_rts[1]), .arb_rtr(arb_rtr[1]), .wr_op(wr_op[1]), .busy(busy[1]),
    .done(done[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int                k;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } acc_t;

  int errors = 0;
  int checks = 0;
  acc_t wlog[$];
  acc_t rlog[$];
  logic [ADDR_W-1:0] cur_base;
  logic [DATA_W-1:0] rd_data [PLANES];
  bit zero_wait;
  int stall_left [2];
  bit hold_en;
  logic [ADDR_W-1:0] hold_addr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // New word for plane p: slot offs replaced by op(old slot, colour slice of plane p).
  function automatic logic [DATA_W-1:0] model_word(input logic [DATA_W-1:0] old, input int p,
                                                   input int offs, input logic [11:0] col,
                                                   input int md);
    logic [63:0] m, w, o, c, r;
    m = (64'd1 << PIX_W) - 64'd1;
    w = 64'(old);
    o = (w >> (offs * PIX_W)) & m;
    c = (64'(col) >> ((PLANES - 1 - p) * PIX_W)) & m;
    case (md)
      0: r = c;
      1: r = o ^ c;
      2: r = o | c;
      default: r = o & c;
    endcase
    w = (w & ~(m << (offs * PIX_W))) | (r << (offs * PIX_W));
    return w[DATA_W-1:0];
  endfunction

  // Memory + arbiter responder for instance k; drives inputs on the falling edge.
  task automatic responder(input int k);
    bit pend = 0;
    int dly = 0;
    logic [DATA_W-1:0] pdata = '0;
    bit prev_hold = 0;
    logic [ADDR_W-1:0] paddr = '0;
    logic [DATA_W-1:0] pdat = '0;
    logic [ADDR_W-1:0] p;
    forever begin
      @(negedge clk);
      if (!rst_) begin
        pend = 0;
        prev_hold = 0;
        arb_rtr[k] = 1'b0;
        bcast_xfc[k] = 1'b0;
        continue;
      end
      if (prev_hold) begin
        check_eq($sformatf("hold_rts%0d", k), 64'(arb_rts[k]), 64'd1);
        check_eq($sformatf("hold_addr%0d", k), 64'(out_addr[k]), 64'(paddr));
        check_eq($sformatf("hold_data%0d", k), 64'(out_data[k]), 64'(pdat));
      end
      bcast_xfc[k] = 1'b0;
      in_data[k] = $urandom;
      if (pend) begin
        if (dly == 0) begin
          bcast_xfc[k] = 1'b1;
          in_data[k] = pdata;
          pend = 0;
        end else begin
          dly--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bcast_xfc[k] = 1'b1;  // spurious strobe with garbage data
      end
      prev_hold = 0;
      if (arb_rts[k]) begin
        if (stall_left[k] > 0 && wr_op[k] == '0) begin
          arb_rtr[k] = 1'b0;
          stall_left[k]--;
          bcast_xfc[k] = 1'b1;
        end else if (hold_en && wr_op[k] == '1 && out_addr[k] == hold_addr) begin
          arb_rtr[k] = 1'b0;
        end else begin
          arb_rtr[k] = zero_wait ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
        if (arb_rtr[k]) begin
          if (wr_op[k] == '1) begin
            wlog.push_back('{k, out_addr[k], out_data[k]});
          end else begin
            rlog.push_back('{k, out_addr[k], '0});
            p = out_addr[k] - cur_base;
            pdata = (p < PLANES) ? rd_data[int'(p)] : 32'hDEAD_BEEF;
            pend = 1;
            dly = zero_wait ? 0 : int'($urandom_range(0, 3));
          end
        end else begin
          prev_hold = 1;
          paddr = out_addr[k];
          pdat = out_data[k];
        end
      end else begin
        arb_rtr[k] = ($urandom_range(0, 1) == 1);
      end
    end
  endtask

  task automatic run_txn(input logic [ADDR_W-1:0] base, input int offs, input logic [11:0] col,
                         input int md, input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                         input logic [DATA_W-1:0] d2, input int stall);
    int cyc;
    int lat [2];
    int dcnt [2];
    bit seen [2];
    bit finished;
    int nexp;
    int exp_lat;
    logic [DATA_W-1:0] w;
    logic [ADDR_W-1:0] ea;
    acc_t got[$];
    cur_base = base;
    rd_data[0] = d0;
    rd_data[1] = d1;
    rd_data[2] = d2;
    wlog.delete();
    rlog.delete();
    stall_left[0] = stall;
    stall_left[1] = stall;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_eq($sformatf("idle_rtr%0d", k), 64'(addr_rtr[k]), 64'd1);
    addr_base = base;
    addr_offset = OFFS_W'(offs);
    color = col;
    mode = 2'(md);
    addr_rts[0] = 1'b1;
    addr_rts[1] = 1'b1;
    cyc = 0;
    finished = 0;
    for (int k = 0; k < 2; k++) begin
      lat[k] = 0;
      dcnt[k] = 0;
      seen[k] = 0;
    end
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        addr_rts[0] = 1'b0;
        addr_rts[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
          check_eq($sformatf("busy%0d", k), 64'(busy[k]), 64'd1);
          check_eq($sformatf("rtr_busy%0d", k), 64'(addr_rtr[k]), 64'd0);
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (done[k]) begin
          dcnt[k]++;
          if (!seen[k]) begin
            seen[k] = 1;
            lat[k] = cyc;
          end
        end
      end
      if (seen[0] && seen[1] && cyc >= lat[0] + 2 && cyc >= lat[1] + 2) begin
        finished = 1;
        break;
      end
    end
    check_eq("txn_complete", 64'(finished), 64'd1);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("done_pulses%0d", k), 64'(dcnt[k]), 64'd1);
      check_eq($sformatf("idle_after%0d", k), 64'(addr_rtr[k]), 64'd1);
      check_eq($sformatf("busy_after%0d", k), 64'(busy[k]), 64'd0);
      check_eq($sformatf("stall_used%0d", k), 64'(stall_left[k]), 64'd0);
      got = wlog.find(item) with (item.k == k);
      nexp = 0;
      exp_lat = 1 + 2 * PLANES + stall;
      for (int p = 0; p < PLANES; p++) begin
        w = model_word(rd_data[p], p, offs, col, md);
        ea = base + ADDR_W'(p);
        if (k == 1 && w == rd_data[p]) begin
          exp_lat += 1;
          continue;
        end
        exp_lat += 2;
        if (nexp < got.size()) begin
          check_eq($sformatf("wr_addr%0d_p%0d", k, p), 64'(got[nexp].a), 64'(ea));
          check_eq($sformatf("wr_data%0d_p%0d", k, p), 64'(got[nexp].d), 64'(w));
        end
        nexp++;
      end
      check_eq($sformatf("wr_count%0d", k), 64'(got.size()), 64'(nexp));
      if (zero_wait) check_eq($sformatf("latency%0d", k), 64'(lat[k]), 64'(exp_lat));
      got = rlog.find(item) with (item.k == k);
      check_eq($sformatf("rd_count%0d", k), 64'(got.size()), 64'(PLANES));
      for (int p = 0; p < PLANES && p < got.size(); p++) begin
        ea = base + ADDR_W'(p);
        check_eq($sformatf("rd_addr%0d_p%0d", k, p), 64'(got[p].a), 64'(ea));
      end
    end
  endtask

  initial begin
    bit found;
    rst_ = 1'b0;
    addr_rts[0] = 1'b0;
    addr_rts[1] = 1'b0;
    addr_base = '0;
    addr_offset = '0;
    color = '0;
    mode = '0;
    zero_wait = 1;
    hold_en = 0;
    hold_addr = '0;
    stall_left[0] = 0;
    stall_left[1] = 0;
    cur_base = '0;
    for (int p = 0; p < PLANES; p++) rd_data[p] = '0;
    fork
      responder(0);
      responder(1);
    join_none

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst_rtr%0d", k), 64'(addr_rtr[k]), 64'd1);
      check_eq($sformatf("rst_arb_rts%0d", k), 64'(arb_rts[k]), 64'd0);
      check_eq($sformatf("rst_busy%0d", k), 64'(busy[k]), 64'd0);
      check_eq($sformatf("rst_done%0d", k), 64'(done[k]), 64'd0);
      check_eq($sformatf("rst_addr%0d", k), 64'(out_addr[k]), 64'd0);
      check_eq($sformatf("rst_data%0d", k), 64'(out_data[k]), 64'd0);
      check_eq($sformatf("rst_wr_op%0d", k), 64'(wr_op[k]), 64'd0);
    end
    rst_ = 1'b1;

    // Directed: replace, XOR (single change), wrap, stalled first read.
    run_txn(17'h00100, 0, 12'hABC, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_txn(17'h0ABCD, 7, 12'hF00, 1, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 0);
    run_txn(17'h1FFFF, 3, 12'h5A3, 2, $urandom, $urandom, $urandom, 0);
    run_txn(17'h00400, 2, 12'h123, 3, $urandom, $urandom, $urandom, 10);

    // Random traffic with random arbiter and return delays.
    zero_wait = 0;
    for (int i = 0; i < 40; i++) begin
      run_txn((i % 8 == 0) ? 17'h1FFFE : ADDR_W'($urandom), int'($urandom_range(0, 7)),
              12'($urandom), int'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
              (i % 5 == 0) ? int'($urandom_range(1, 6)) : 0);
    end

    // Reset while the plain instance waits in the write request of plane 1.
    zero_wait = 1;
    cur_base = 17'h00200;
    for (int p = 0; p < PLANES; p++) rd_data[p] = $urandom;
    hold_addr = cur_base + 17'd1;
    hold_en = 1;
    @(negedge clk);
    addr_base = cur_base;
    addr_offset = 3'd1;
    color = 12'h7E1;
    mode = 2'd0;
    addr_rts[0] = 1'b1;
    addr_rts[1] = 1'b1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (i == 0) begin
        addr_rts[0] = 1'b0;
        addr_rts[1] = 1'b0;
      end
      if (arb_rts[0] && wr_op[0] == '1 && out_addr[0] == hold_addr) found = 1;
    end
    check_eq("reach_wr_pl1", 64'(found), 64'd1);
    rst_ = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_arb_rts", 64'(arb_rts[0]), 64'd0);
    check_eq("mid_rst_rtr", 64'(addr_rtr[0]), 64'd1);
    check_eq("mid_rst_addr", 64'(out_addr[0]), 64'd0);
    check_eq("mid_rst_data", 64'(out_data[0]), 64'd0);
    check_eq("mid_rst_busy", 64'(busy[0]), 64'd0);
    @(negedge clk);
    rst_ = 1'b1;
    hold_en = 0;
    repeat (6) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check_eq($sformatf("post_rst_rts%0d", k), 64'(arb_rts[k]), 64'd0);
        check_eq($sformatf("post_rst_busy%0d", k), 64'(busy[k]), 64'd0);
      end
    end

    // Normal operation after the abandoned transaction.
    run_txn(17'h01234, 5, 12'h9C4, 1, $urandom, $urandom, $urandom, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
